// File: rtl/instruction_fetch.sv
// Fetch stage: holds the byte PC, drives the instruction ROM through its read
// latency and latches the returned word into IR with a one-cycle FetchDone pulse.
module instruction_fetch #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  FetchStart,
    input  logic                  PCLoad,
    input  logic [31:0]           PCIn,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic [DATA_WIDTH-1:0] IR,
    output logic [31:0]           PC,
    output logic [31:0]           InstrAddr,
    output logic                  Busy,
    output logic                  FetchDone
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_READ = 3'(MEM_LATENCY - 1);

    state_t                  state, state_nxt;
    logic [2:0]              cnt, cnt_nxt;
    logic [31:0]             pc_p1;
    logic [DATA_WIDTH-1:0]   ir_p1;
    logic [31:0]             instr_addr_p1;
    logic                    done_vld_p1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (!PCLoad && FetchStart) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == LAST_READ) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture boundary: IR, InstrAddr and the done pulse register together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pc_p1         <= RESET_PC;
            ir_p1         <= '0;
            instr_addr_p1 <= '0;
            done_vld_p1   <= 1'b0;
        end else if (Enable) begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            done_vld_p1 <= (state == CAPTURE);
            if (state == IDLE && PCLoad) begin
                pc_p1 <= word_align(PCIn);
            end
            if (state == CAPTURE) begin
                ir_p1         <= MemData;
                instr_addr_p1 <= pc_p1;
                pc_p1         <= pc_p1 + 32'd4;
            end
        end
    end

    // A pulse pending while Enable is low is held and shown once Enable returns.
    assign MemAddress = pc_p1[ADDR_WIDTH+1:2];
    assign MemRead    = Enable && (state == READ);
    assign FetchDone  = Enable && done_vld_p1;
    assign Busy       = (state != IDLE);
    assign IR         = ir_p1;
    assign PC         = pc_p1;
    assign InstrAddr  = instr_addr_p1;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the CSC317 processor. Holds the byte-addressed PC, drives the word address and clock-enable of the on-chip instruction ROM, waits out the ROM read latency, and latches the returned word into IR for the control step counter. Sits between the control unit and the ROM; its IR and PC outputs feed decode and the register-peek hex display.

## Interface

Parameters:
- ADDR_WIDTH, 8, ROM word-address width.
- DATA_WIDTH, 32, instruction width.
- MEM_LATENCY, 1, ROM read latency in clocks, legal range 1..4.
- RESET_PC, 32'h0, PC value after reset. Low 2 bits must be 0.

Ports:
- Clock  in  1  system clock. One clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  processor run enable. Low freezes all state.
- FetchStart  in  1  request one instruction fetch.
- PCLoad  in  1  load PC from PCIn (branch or jump).
- PCIn  in  32  new PC, byte address.
- MemAddress  out  ADDR_WIDTH  ROM word address, PC[ADDR_WIDTH+1:2].
- MemRead  out  1  ROM clken.
- MemData  in  DATA_WIDTH  ROM q.
- IR  out  DATA_WIDTH  fetched instruction.
- PC  out  32  current PC.
- InstrAddr  out  32  byte address of the instruction in IR.
- Busy  out  1  fetch in progress.
- FetchDone  out  1  one-cycle pulse; IR valid.

## Operation

- States: IDLE, READ, CAPTURE.
- IDLE: PCLoad=1 loads PC <= {PCIn[31:2],2'b00}. Otherwise FetchStart=1 moves to READ and clears the latency counter. PCLoad and FetchStart together: load wins, FetchStart is dropped and not queued.
- READ: MemRead=1. Counter increments each enabled cycle. Exit to CAPTURE after MEM_LATENCY READ cycles.
- CAPTURE: MemRead=0, so the ROM holds q. IR <= MemData, InstrAddr <= PC, PC <= PC+4, FetchDone <= 1. Next state IDLE.
- PCLoad and FetchStart are ignored in READ and CAPTURE.
- MemAddress is always combinationally PC[ADDR_WIDTH+1:2], including in IDLE.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 0. MemAddress takes the truncated bits, so ROM addressing wraps at 2^ADDR_WIDTH words.
- Busy = (state != IDLE), combinational.
- Enable=0: state, counter, PC, IR and InstrAddr hold. MemRead is forced to 0. FetchDone is forced to 0 and its pending pulse is held until Enable returns. Inputs are ignored.

## Timing

- Reset values: state=IDLE, PC=RESET_PC, IR=0, InstrAddr=0, FetchDone=0, counter=0. This gives Busy=0 and MemRead=0.
- Reset mid-fetch aborts the fetch. IR is not updated and no FetchDone is issued.
- Fetch latency with Enable held high (counting from the FetchStart cycle as cycle 0):
  - READ occupies cycles 1..MEM_LATENCY.
  - CAPTURE occupies cycle MEM_LATENCY+1.
  - FetchDone=1 and the new IR/PC are visible in cycle MEM_LATENCY+2, with state back in IDLE.
- FetchStart may be asserted in the FetchDone cycle. This gives back-to-back fetches every MEM_LATENCY+2 cycles.
- PCLoad in IDLE: the new PC and MemAddress are visible the next cycle.
- MemRead is high for exactly MEM_LATENCY enabled cycles per fetch.

## Test plan

- Reset, RESET_PC=0, ROM[0]=32'h12345678, MEM_LATENCY=1. FetchStart at cycle 0 -> MemRead=1 in cycle 1 only; FetchDone=1 in cycle 3; IR=32'h12345678, InstrAddr=0, PC=4.
- Three back-to-back fetches, each FetchStart in the previous FetchDone cycle, ROM[0..2]=A,B,C -> FetchDone at cycles 3, 6, 9; IR=A,B,C in turn; final PC=12.
- PCLoad=1 with PCIn=32'h0000_0043 and FetchStart=1 in the same IDLE cycle -> PC=32'h40 next cycle, MemAddress=8'h10, no fetch; a later FetchStart returns ROM[16] with InstrAddr=32'h40.
- MEM_LATENCY=3 with Enable dropped for 2 cycles in the second READ cycle -> MemRead=0 and state held while Enable is low; FetchDone arrives 2 cycles late (cycle 7); PCLoad issued during READ has no effect.
- PC=32'hFFFFFFFC, then fetch -> PC=0, InstrAddr=32'hFFFFFFFC, MemAddress=8'hFF during READ.
- Reset asserted in the READ cycle with IR=A -> next cycle state IDLE, PC=RESET_PC, IR=0, FetchDone never asserted.
